// File: rtl/jpeg_frame_ctrl.sv
// ---------------------------------------------------------------------------
// jpeg_frame_ctrl
//   Frame-level sequencer for the UART -> JPEG coder -> UART path.
//   Hunts for a two-byte sync header on the RX byte stream, forwards exactly
//   WIDTH*HEIGHT pixel bytes to the coder input adapter, passes coder output
//   bytes straight through to UART TX until the EOI marker (FF D9), then
//   sends ACK_BYTE. A watchdog aborts stalled frames: it flushes the coder
//   and sends NAK_BYTE.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data/rx_valid      received UART byte stream (no backpressure)
//   pix_data/pix_valid    registered pixel byte stream to the coder adapter
//   enc_data/enc_valid    coder output byte stream
//   enc_ready             coder byte accepted when enc_valid & enc_ready
//   tx_data/tx_valid      byte to UART TX, held until tx_ready
//   tx_ready              UART TX can accept
//   coder_flush           1-cycle pulse: resynchronise coder and adapters
//   busy                  high whenever the FSM is not idle
//   frame_done            1-cycle pulse on the ACK handshake
//   err_timeout           1-cycle pulse on watchdog abort
//   frame_cnt             completed frame count, wraps
// ---------------------------------------------------------------------------
module jpeg_frame_ctrl #(
    parameter int unsigned WIDTH    = 512,
    parameter int unsigned HEIGHT   = 512,
    parameter logic [7:0]  SYNC0    = 8'hA5,
    parameter logic [7:0]  SYNC1    = 8'h5A,
    parameter logic [7:0]  ACK_BYTE = 8'h06,
    parameter logic [7:0]  NAK_BYTE = 8'h15,
    parameter int unsigned TIMEOUT  = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic [7:0]  enc_data,
    input  logic        enc_valid,
    output logic        enc_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        coder_flush,
    output logic        busy,
    output logic        frame_done,
    output logic        err_timeout,
    output logic [15:0] frame_cnt
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned CW   = $clog2(NPIX + 1);
    localparam int unsigned WW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] PIX_LAST = CW'(NPIX - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_RECV  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]    r_state;
    logic [CW-1:0] r_pix_cnt;
    logic [WW-1:0] r_wd;
    logic          r_eoi_seen;
    logic          r_prev_ff;
    logic [7:0]    r_pix_data;
    logic          r_pix_valid;
    logic          r_abort;
    logic [15:0]   r_frame_cnt;

    logic w_active;
    logic w_enc_hs;
    logic w_timeout;

    assign w_active  = (r_state == S_RECV) || (r_state == S_DRAIN);
    assign w_enc_hs  = w_active && enc_valid && tx_ready;
    assign w_timeout = w_active && (r_wd == WD_LAST);

    // Coder output is a combinational passthrough while a frame is live;
    // otherwise TX carries the FSM's status byte.
    always_comb begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        enc_ready = w_active && tx_ready;
        case (r_state)
            S_RECV, S_DRAIN: begin
                tx_data  = enc_data;
                tx_valid = enc_valid;
            end
            S_ACK: begin
                tx_data  = ACK_BYTE;
                tx_valid = 1'b1;
            end
            S_ERR: begin
                tx_data  = NAK_BYTE;
                tx_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign pix_data    = r_pix_data;
    assign pix_valid   = r_pix_valid;
    assign coder_flush = r_abort;
    assign err_timeout = r_abort;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = (r_state == S_ACK) && tx_ready;
    assign frame_cnt   = r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pix_cnt   <= '0;
            r_wd        <= '0;
            r_eoi_seen  <= 1'b0;
            r_prev_ff   <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_abort     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_pix_valid <= 1'b0;
            r_abort     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid && rx_data == SYNC0) r_state <= S_SYNC;
                end
                S_SYNC: begin
                    if (rx_valid) begin
                        if (rx_data == SYNC1) begin
                            r_state    <= S_RECV;
                            r_pix_cnt  <= '0;
                            r_wd       <= '0;
                            r_eoi_seen <= 1'b0;
                            r_prev_ff  <= 1'b0;
                        end else if (rx_data != SYNC0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RECV, S_DRAIN: begin
                    if (w_enc_hs) begin
                        r_prev_ff <= (enc_data == 8'hFF);
                        if (r_prev_ff && enc_data == 8'hD9) r_eoi_seen <= 1'b1;
                    end
                    if (rx_valid || w_enc_hs) r_wd <= '0;
                    else                      r_wd <= r_wd + 1'b1;
                    // Watchdog wins; an rx byte in the abort cycle is dropped.
                    if (w_timeout) begin
                        r_state <= S_ERR;
                        r_abort <= 1'b1;
                    end else if (r_state == S_RECV) begin
                        if (rx_valid) begin
                            r_pix_data  <= rx_data;
                            r_pix_valid <= 1'b1;
                            r_pix_cnt   <= r_pix_cnt + 1'b1;
                            if (r_pix_cnt == PIX_LAST) r_state <= S_DRAIN;
                        end
                    end else if (r_eoi_seen && !w_enc_hs) begin
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (tx_ready) begin
                        r_state     <= S_IDLE;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end
                S_ERR: begin
                    if (tx_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
